// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer and related
// input-conditioning blocks.
package debounce_pkg;

  // Four filter states: two stable levels and two qualification phases.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } deb_state_t;

  // Default synchronizer depth; two flops are enough for lab clock rates.
  localparam int DEB_SYNC_DEFAULT = 2;

endpackage

// File: rtl/sync_chain.sv
// Metastability synchronizer: a plain shift register with asynchronous
// active-low clear. Only the final stage may be read by downstream logic.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_r;

  // Shift the raw input through the chain one flop per clock.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stage_r <= '0;
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Button/switch debouncer: synchronizer followed by a counter-based
// stability filter. Produces a clean level plus one-cycle rise/fall pulses.
// Build option: define BUTTON_DEBOUNCER_TOGGLE_EN to add the `toggle`
// output, which flips once per debounced press.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = DEB_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  // Counter is cleared on every state change, so it only needs to reach
  // STABLE_CYCLES-1 and can never wrap.
  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic           s_s;
  deb_state_t     state_r;
  logic [CW-1:0]  cnt_r;
  logic           level_r;
  logic           rise_r;
  logic           fall_r;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  logic           toggle_r;
`endif

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (din),
    .q     (s_s)
  );

  // Stability filter: qualify each new synchronized value for
  // STABLE_CYCLES samples before committing it to the level output.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r  <= IDLE_LO;
      cnt_r    <= '0;
      level_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
      toggle_r <= 1'b0;
`endif
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        IDLE_LO: begin
          if (s_s) begin
            state_r <= WAIT_HI;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= IDLE_LO;
          end
        end
        WAIT_HI: begin
          if (!s_s) begin
            state_r <= IDLE_LO;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= IDLE_HI;
            cnt_r    <= '0;
            level_r  <= 1'b1;
            rise_r   <= 1'b1;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
            toggle_r <= ~toggle_r;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s_s) begin
            state_r <= WAIT_LO;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= IDLE_HI;
          end
        end
        WAIT_LO: begin
          if (s_s) begin
            state_r <= IDLE_HI;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_LO;
            cnt_r   <= '0;
            level_r <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE_LO;
          cnt_r   <= '0;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  assign toggle = toggle_r;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed scoreboard bench for button_debouncer (STABLE_CYCLES=4,
// SYNC_STAGES=2). Expected {level,rise,fall} values are queued as each
// input value is driven and popped/compared one time unit after the edge.
module tb_button_debouncer;

  logic clk;
  logic clr_n;
  logic din;
  logic level;
  logic rise;
  logic fall;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  logic toggle;
  logic exp_toggle;
`endif

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  button_debouncer #(
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall)
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    ,
    .toggle (toggle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic check_out(input string tag);
    exp_t e;
    exp_t got;
    got = {level, rise, fall};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed l/r/f=%b", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s: observed l/r/f=%b expected %b", tag, got, e);
      end
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
      if (e.rise) exp_toggle = ~exp_toggle;
      checks++;
      assert (toggle === exp_toggle) else begin
        errors++;
        $error("FAIL %s_toggle: observed %b expected %b", tag, toggle, exp_toggle);
      end
`endif
    end
  endtask

  // Drive din before the next edge, queue the expected outputs after it.
  task automatic step(input logic d, input logic el, input logic er,
                      input logic ef, input string tag);
    exp_t e;
    din = d;
    e.level = el;
    e.rise  = er;
    e.fall  = ef;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // Clean press from a settled low level: 5 quiet edges, pulse on edge 6.
  task automatic press(input string tag);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, {tag, "_wait"});
    step(1'b1, 1'b1, 1'b1, 1'b0, {tag, "_rise"});
    step(1'b1, 1'b1, 1'b0, 1'b0, {tag, "_after"});
  endtask

  // Clean release from a settled high level.
  task automatic release_btn(input string tag);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, {tag, "_wait"});
    step(1'b0, 1'b0, 1'b0, 1'b1, {tag, "_fall"});
    step(1'b0, 1'b0, 1'b0, 1'b0, {tag, "_after"});
  endtask

  // Compare without a clock edge (used right after asserting reset).
  task automatic check_now(input logic el, input string tag);
    exp_t e;
    e.level = el;
    e.rise  = 1'b0;
    e.fall  = 1'b0;
    exp_q.push_back(e);
    #1;
    check_out(tag);
  endtask

  initial begin
    din   = 1'b0;
    clr_n = 1'b0;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    exp_toggle = 1'b0;
`endif
    #3;
    check_now(1'b0, "reset");
    @(negedge clk);
    clr_n = 1'b1;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Clean press, hold, then clean release.
    press("press1");
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, "press1_hold");
    release_btn("rel1");
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, "rel1_idle");

    // Three-sample glitch must be filtered out entirely.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, "glitch_hi");
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, "glitch_lo");

    // Bouncy press 1,0,1,1,0 then steady 1: rise on the 6th edge of the final 1.
    step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_3");
    step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_4");
    step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_5");
    press("bounce_final");
    release_btn("rel2");

    // Reset four edges into a qualification: no pulse, re-qualify afterwards.
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, "rstmid_wait");
    clr_n = 1'b0;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    exp_toggle = 1'b0;
`endif
    check_now(1'b0, "rstmid_now");
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, "rstmid_held");
    clr_n = 1'b1;
    press("rstmid_after");

    // Reset while level is high clears it without a clock.
    clr_n = 1'b0;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    exp_toggle = 1'b0;
`endif
    check_now(1'b0, "rsthi_now");
    step(1'b1, 1'b0, 1'b0, 1'b0, "rsthi_held");
    clr_n = 1'b1;
    press("rsthi_after");
    release_btn("rel3");

    // Two more press/release cycles (toggle sequence 1,0,1 when enabled).
    press("press2");
    release_btn("rel4");
    press("press3");
    release_btn("rel5");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw asynchronous mechanical input (button or switch) into a clean, clock-synchronous level and single-cycle edge pulses.
- Sits directly upstream of the lab's D flip-flops.
- `rise`/`fall` pulses drive a flip-flop's enable or clear input; `level` drives its data input.
- Consists of a synchronizer chain followed by a counter-based stability filter.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized samples of a new value required before `level` changes; legal range 2 to 2^24. Use 4 in simulation; about 1_000_000 on the board.
- SYNC_STAGES, 2: depth of the metastability synchronizer; legal range 2 to 4.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clr_n  in  1  asynchronous active-low reset.
- din  in  1  raw asynchronous input; bounces; no timing relation to clk.
- level  out  1  debounced, synchronous version of din.
- rise  out  1  one-cycle pulse in the same cycle `level` goes 0->1.
- fall  out  1  one-cycle pulse in the same cycle `level` goes 1->0.

Behaviour:
- Reset: `clr_n`=0 immediately, without a clock, clears the synchronizer flops, counter, `level`, `rise`, `fall` and (if compiled in) `toggle` to 0, and forces the state to IDLE_LO. Release of `clr_n` is treated as synchronous to clk by the integrator.
- Synchronizer: `din` passes through SYNC_STAGES flops; the last stage is `s`. No logic reads `din` or any earlier stage.
- Counter: width $clog2(STABLE_CYCLES+1). It is cleared on every state change, so it never wraps.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. Transitions are evaluated at each rising clk edge:
  - IDLE_LO: if s=1 -> WAIT_HI, cnt<=1; else stay.
  - WAIT_HI:
    - if s=0 -> IDLE_LO, cnt<=0 (abort, no output change);
    - else if cnt==STABLE_CYCLES-1 -> IDLE_HI, level<=1, rise<=1, cnt<=0;
    - else cnt<=cnt+1.
  - IDLE_HI: if s=0 -> WAIT_LO, cnt<=1; else stay.
  - WAIT_LO: mirror of WAIT_HI. On s=1 -> IDLE_HI (abort); on completion -> IDLE_LO, level<=0, fall<=1.
- Pulses: `rise` and `fall` are registered and default to 0 every cycle, so each is high for exactly one cycle. They are never high together. Neither can repeat before the level has changed again, which takes at least STABLE_CYCLES cycles.
- Latency: a clean step on `din` set up before edge 1 changes `level` (with its pulse) after edge SYNC_STAGES+STABLE_CYCLES.
- Filtering: any excursion of `s` lasting fewer than STABLE_CYCLES samples produces no output activity. Each bounce restarts the count from 1.
- Reset mid-WAIT: the pending transition is discarded and no pulse is emitted. After reset the block re-qualifies from IDLE_LO.
- Input held high through reset: after release, `level` rises after SYNC_STAGES+STABLE_CYCLES edges and `rise` fires once.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_TOGGLE_EN.
- Defined: adds output port `toggle` (out, 1). `toggle` resets to 0 and inverts in the cycle `rise` is asserted, i.e. one flip per debounced press. This is the press-to-toggle used for LED labs.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Package `debounce_pkg`:
  - typedef enum logic [1:0] `deb_state_t` {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO};
  - localparam DEB_SYNC_DEFAULT = 2.
- Sub-module `sync_chain`:
  - parameter STAGES; ports clk, clr_n, d, q; a plain shift register with async active-low clear.
  - Instantiated once; reusable by other input-conditioning blocks.
- FSM, counter and pulse registers stay in `button_debouncer`.

Test Plan:
All scenarios use STABLE_CYCLES=4 and SYNC_STAGES=2.
1. Clean press: `din` 0->1 before edge 1, held -> `level`=1 and `rise`=1 after edge 6; `rise`=0 after edge 7; `fall` stays 0.
2. Glitch: `din`=1 for 3 cycles, then 0 -> `level`, `rise` and `fall` remain 0 throughout; FSM returns to IDLE_LO.
3. Bouncy press: `din` pattern 1,0,1,1,0,1 then steady 1 -> exactly one `rise`, 6 edges after the final 0->1 transition.
4. Release: from `level`=1, `din` 1->0 held -> `level`=0 and `fall`=1 for one cycle after edge 6; `rise` stays 0.
5. Reset mid-qualification: `clr_n` pulsed low 4 edges into a press -> outputs 0 immediately and no `rise` during reset; with `din` still 1 after release, `rise` fires after 6 edges.
6. With BUTTON_DEBOUNCER_TOGGLE_EN defined: three clean presses -> `toggle` goes 1, 0, 1, changing in each `rise` cycle and unaffected by releases.
